rr_mux4to1: RTL and testbench
=============================

# rr_mux4to1

Sequential 4-to-1 round-robin multiplexer that merges four valid/ready input channels into one registered output stream tagged with its source index. It is the collecting end matching the 1-to-4 demultiplexer: traffic fanned out on `sel` is gathered back here, and `out_sel` carries the channel number that the demux uses as `sel`. It sits between four producer channels and a single consumer, giving fair, starvation-free access and a throughput of one word per cycle.

## Interface
- `DATA_W`, default 8: width of each data word.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  grant enable; while low, no new word is accepted, but a held word still drains.
- `in_valid`  in  4  per-channel request; bit i belongs to `in_data{i}`.
- `in_data0`..`in_data3`  in  DATA_W each  channel payloads.
- `in_ready`  out  4  one-hot or zero; bit i high means channel i's word is taken at this edge.
- `out_valid`  out  1  the output register holds a word.
- `out_data`  out  DATA_W  held word.
- `out_sel`  out  2  source channel of the held word.
- `out_ready`  in  1  the consumer takes the held word at this edge.

## Operation
- State: output register (`out_valid`, `out_data`, `out_sel`) and 2-bit priority pointer `ptr`.
- `load_ok = en & (~out_valid | out_ready)`.
- Grant: the first i with `in_valid[i]=1`, searching `ptr, ptr+1, ptr+2, ptr+3` mod 4. If no bit is set, there is no grant.
- `in_ready[i] = load_ok & grant[i]`. This is combinational from `in_valid`, `en`, `out_ready`, `out_valid` and `ptr`, with at most one bit high.
- On an edge with a grant and `load_ok`:
  - `out_data <= in_data{g}`, `out_sel <= g`, `out_valid <= 1`.
  - `ptr <= g+1` mod 4, wrapping 3 to 0.
- On an edge with `out_valid & out_ready` and no grant: `out_valid <= 0`. `out_data` and `out_sel` keep their last values.
- While `out_valid & ~out_ready`: `out_data` and `out_sel` stay stable, all `in_ready` bits are 0, and `ptr` does not change.
- `ptr` changes only on a grant.
- Sources must hold `in_valid` and `in_data` until they see `in_ready`. The arbiter still behaves correctly if a source withdraws a request before being granted.

## Timing
- Reset (asynchronous assert): `out_valid=0`, `out_data=0`, `out_sel=0`, `ptr=0`, so every `in_ready` bit is 0.
- Latency: a word accepted at edge N is visible on `out_*` after edge N, i.e. in cycle N+1. There is no combinational path from `in_data` to `out_data`.
- Throughput: one word per cycle when `out_ready` is held high.
- Simultaneous consume and load: the held word leaves and the new word loads on the same edge, so `out_valid` stays at 1 with no bubble.
- `en` falling while a word is held: the held word is still delivered on `out_ready`, and no further loads occur.
- `en` is sampled in the same cycle it is used; there is no pipeline delay on it.
- All four channels requesting continuously: grants go 0,1,2,3,0,… Worst-case wait for any requester is 3 grants.
- Reset asserted mid-transfer: the held word is dropped, and the pointer and arbitration restart at channel 0.

## Structure
- Shared constants in the team's common header/package: `NUM_CH=4`, `SEL_W=2`.
- Sub-module `rr_arb4`: purely combinational round-robin picker. Inputs are `req[3:0]` and `ptr[1:0]`; outputs are `grant[3:0]` (one-hot), `grant_idx[1:0]` and `any`.
- The top level owns the output register, the pointer and the handshake logic.

## Test plan
- Reset then single request: `in_valid=4'b0100`, `in_data2=8'hA5`, `en=1`, `out_ready=1`.
  - `in_ready=4'b0100` in the same cycle.
  - Next cycle: `out_valid=1`, `out_data=A5`, `out_sel=2`.
  - Pointer becomes 3.
- All four channels request with data 10/11/12/13 and `out_ready=1`: outputs on consecutive cycles are 10,11,12,13,10 with `out_sel` 0,1,2,3,0, and `out_valid` never drops.
- Backpressure: a word is held and `out_ready=0` for 5 cycles while other channels request.
  - `in_ready=0` and `out_data`/`out_sel` are unchanged throughout.
  - When `out_ready` rises, the next requester after `ptr` loads on the same edge.
- Enable gating: a word is held and `en` drops.
  - The held word is delivered on `out_ready`, then `out_valid=0`.
  - `in_ready=0` while `en=0`, even with all `in_valid=1`.
- Wrap and fairness: with `ptr=3` and `in_valid=4'b1001`, channel 3 is granted first, then channel 0.
- Asynchronous reset mid-stream, asserted between clock edges: all outputs read 0 immediately, and the first grant after release goes to the lowest requesting channel.

Source files
------------

// File: rtl/rr_mux4to1_pkg.sv
// Shared constants and helpers for the 4-channel round-robin collector.
package rr_mux4to1_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  // Channel-number addition modulo NUM_CH (the result width does the wrap).
  function automatic logic [SEL_W-1:0] ch_add(input logic [SEL_W-1:0] a,
                                              input logic [SEL_W-1:0] b);
    return a + b;
  endfunction
endpackage

// File: rtl/rr_mux4to1_arb4.sv
// Combinational round-robin picker: first requester at or after ptr.
module rr_arb4
  import rr_mux4to1_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx,
  output logic              any
);

  logic [SEL_W-1:0] idx;

  // Scan from the farthest offset down to ptr, so the closest requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = ch_add(ptr, SEL_W'(k));
      if (req[idx]) begin
        grant_idx = idx;
        any       = 1'b1;
      end
    end
    if (any) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/rr_mux4to1.sv
// Four valid/ready channels merged into one registered stream tagged with
// the source channel; fair round-robin arbitration, one word per cycle.
module rr_mux4to1
  import rr_mux4to1_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_CH-1:0] in_valid,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [DATA_W-1:0] in_data2,
  input  logic [DATA_W-1:0] in_data3,
  output logic [NUM_CH-1:0] in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]  out_sel,
  input  logic              out_ready
);

  logic [SEL_W-1:0]  ptr;
  logic [NUM_CH-1:0] grant;
  logic [SEL_W-1:0]  grant_idx;
  logic              any;
  logic              load_ok;
  logic              take;
  logic [DATA_W-1:0] data_arr [NUM_CH];

  assign data_arr[0] = in_data0;
  assign data_arr[1] = in_data1;
  assign data_arr[2] = in_data2;
  assign data_arr[3] = in_data3;

  rr_arb4 u_arb (
    .req       (in_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  // The register can take a word when empty or being drained this edge.
  assign load_ok  = en & (~out_valid | out_ready);
  assign take     = load_ok & any;
  // Held low during reset so no source believes its word was taken.
  assign in_ready = (load_ok & ~rst) ? grant : '0;

  // Output register and priority pointer; pointer moves only on a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= data_arr[grant_idx];
      out_sel   <= grant_idx;
      ptr       <= ch_add(grant_idx, SEL_W'(1));
    end else if (out_valid & out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux4to1.sv
// Self-checking bench for rr_mux4to1: directed table, async reset, random.
module tb_rr_mux4to1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] in_valid = '0;
  logic [7:0] in_data0 = '0, in_data1 = '0, in_data2 = '0, in_data3 = '0;
  logic [3:0] in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] out_sel;
  logic       out_ready = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  rr_mux4to1 #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
    .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sel(out_sel), .out_ready(out_ready)
  );

  typedef struct {
    logic            rst, en;
    logic [3:0]      vld;
    logic [3:0][7:0] d;
    logic            ordy;
    logic [3:0]      exp_rdy;
    logic            exp_v;
    logic [7:0]      exp_d;
    logic [1:0]      exp_s;
  } row_t;

  function automatic row_t r(input logic rst_i, input logic en_i, input logic [3:0] vld,
                             input logic [31:0] d, input logic ordy, input logic [3:0] er,
                             input logic ev, input logic [7:0] ed, input logic [1:0] es);
    row_t x;
    x.rst = rst_i; x.en = en_i; x.vld = vld; x.d = d; x.ordy = ordy;
    x.exp_rdy = er; x.exp_v = ev; x.exp_d = ed; x.exp_s = es;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic en_i, input logic [3:0] vld, input logic [31:0] d,
                       input logic ordy);
    en = en_i; in_valid = vld; out_ready = ordy;
    in_data0 = d[7:0]; in_data1 = d[15:8]; in_data2 = d[23:16]; in_data3 = d[31:24];
  endtask

  // Reference model: output register contents and priority pointer.
  logic       m_v;
  logic [7:0] m_d;
  logic [1:0] m_s;
  int         m_ptr;

  // Lowest-offset requester walking forward from the pointer; -1 when idle.
  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++)
      if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  localparam logic [31:0] D = 32'h13121110;
  row_t tbl[$];

  initial begin
    row_t rw;
    int g;
    logic lo;
    logic [3:0] er;
    logic [31:0] rd;

    // single request, pointer wrap, drain
    tbl.push_back(r(1, 1, 4'b0000, D, 1, 4'b0000, 0, 8'h00, 0));
    tbl.push_back(r(0, 1, 4'b0100, 32'h00A50000, 1, 4'b0100, 1, 8'hA5, 2));
    tbl.push_back(r(0, 1, 4'b1001, D, 1, 4'b1000, 1, 8'h13, 3));
    tbl.push_back(r(0, 1, 4'b0001, D, 1, 4'b0001, 1, 8'h10, 0));
    tbl.push_back(r(0, 1, 4'b0000, D, 1, 4'b0000, 0, 8'h10, 0));
    // all four requesting: 0,1,2,3,0 with no bubble
    tbl.push_back(r(1, 1, 4'b0000, D, 1, 4'b0000, 0, 8'h00, 0));
    tbl.push_back(r(0, 1, 4'b1111, D, 1, 4'b0001, 1, 8'h10, 0));
    tbl.push_back(r(0, 1, 4'b1111, D, 1, 4'b0010, 1, 8'h11, 1));
    tbl.push_back(r(0, 1, 4'b1111, D, 1, 4'b0100, 1, 8'h12, 2));
    tbl.push_back(r(0, 1, 4'b1111, D, 1, 4'b1000, 1, 8'h13, 3));
    tbl.push_back(r(0, 1, 4'b1111, D, 1, 4'b0001, 1, 8'h10, 0));
    // backpressure for five cycles, then next requester after ptr
    for (int i = 0; i < 5; i++)
      tbl.push_back(r(0, 1, 4'b1111, D, 0, 4'b0000, 1, 8'h10, 0));
    tbl.push_back(r(0, 1, 4'b1111, D, 1, 4'b0010, 1, 8'h11, 1));
    // enable gating: held word drains, nothing new loads
    tbl.push_back(r(0, 0, 4'b1111, D, 0, 4'b0000, 1, 8'h11, 1));
    tbl.push_back(r(0, 0, 4'b1111, D, 1, 4'b0000, 0, 8'h11, 1));
    tbl.push_back(r(0, 0, 4'b1111, D, 1, 4'b0000, 0, 8'h11, 1));
    tbl.push_back(r(0, 1, 4'b1111, D, 1, 4'b0100, 1, 8'h12, 2));

    @(posedge clk); #1;
    foreach (tbl[i]) begin
      rw = tbl[i];
      rst = rw.rst;
      drive(rw.en, rw.vld, rw.d, rw.ordy);
      #1 chk($sformatf("tbl%0d in_ready", i), {28'd0, in_ready}, {28'd0, rw.exp_rdy});
      @(posedge clk); #1;
      chk($sformatf("tbl%0d out_valid", i), {31'd0, out_valid}, {31'd0, rw.exp_v});
      chk($sformatf("tbl%0d out_data", i), {24'd0, out_data}, {24'd0, rw.exp_d});
      chk($sformatf("tbl%0d out_sel", i), {30'd0, out_sel}, {30'd0, rw.exp_s});
      rst = 1'b0;
    end

    // async reset asserted between edges while a word is held
    drive(1, 4'b1111, D, 0);
    #3 rst = 1'b1;
    #1;
    chk("arst out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst out_data", {24'd0, out_data}, 32'd0);
    chk("arst out_sel", {30'd0, out_sel}, 32'd0);
    chk("arst in_ready", {28'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1, 4'b0110, D, 1);
    #1 chk("post-rst in_ready", {28'd0, in_ready}, 32'b0010);
    @(posedge clk); #1;
    chk("post-rst out_data", {24'd0, out_data}, 32'h11);
    chk("post-rst out_sel", {30'd0, out_sel}, 32'd1);
    m_v = 1'b1; m_d = 8'h11; m_s = 2'd1; m_ptr = 2;

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      rd = $urandom;
      drive(($urandom_range(0, 7) != 0), 4'($urandom), rd, ($urandom_range(0, 3) != 0));
      #1;
      g  = pick(in_valid, m_ptr);
      lo = en && (!m_v || out_ready);
      er = (lo && g >= 0) ? 4'(1 << g) : 4'b0000;
      chk("rnd in_ready", {28'd0, in_ready}, {28'd0, er});
      @(posedge clk);
      if (lo && g >= 0) begin
        m_v = 1'b1; m_d = rd[g*8 +: 8]; m_s = 2'(g); m_ptr = (g + 1) % 4;
      end else if (m_v && out_ready) begin
        m_v = 1'b0;
      end
      #1;
      chk("rnd out_valid", {31'd0, out_valid}, {31'd0, m_v});
      chk("rnd out_data", {24'd0, out_data}, {24'd0, m_d});
      chk("rnd out_sel", {30'd0, out_sel}, {30'd0, m_s});
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
